// File: rtl/sam_encoder_if.sv
// sam_encoder_if: host request/descriptor inputs and UART TX byte handshake
// for the SAM frame encoder. The encoder uses the slave modport; the
// host/UART side uses the master modport.
interface sam_encoder_if;
    logic       send_req;
    logic [1:0] kind1;
    logic [1:0] kind2;
    logic [1:0] kind3;
    logic [1:0] idx1;
    logic [1:0] idx2;
    logic [1:0] idx3;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic       busy;
    logic       msg_done;

    modport master (
        output send_req, kind1, kind2, kind3, idx1, idx2, idx3, tx_done,
        input  tx_data, tx_start, busy, msg_done
    );

    modport slave (
        input  send_req, kind1, kind2, kind3, idx1, idx2, idx3, tx_done,
        output tx_data, tx_start, busy, msg_done
    );
endinterface

// File: rtl/sam_encoder.sv
// sam_encoder: serialises a three-subunit SAM command into the ASCII frame
// "SAM-1.ttt-2.ttt-3.ttt-#" one byte per UART start/done handshake.
// Optional feature: define SAM_ENC_CRLF_EN to append CR (8'h0D) and
// LF (8'h0A) after '#', extending the frame to 25 bytes.
module sam_encoder #(
    parameter int MSG_LEN = 23
) (
    input  logic         clk,
    input  logic         rst,
    sam_encoder_if.slave bus
);

`ifdef SAM_ENC_CRLF_EN
    localparam int FRAME_LEN = MSG_LEN + 2;
`else
    localparam int FRAME_LEN = MSG_LEN;
`endif
    localparam logic [4:0]  LAST_IDX  = 5'(FRAME_LEN - 1);
    localparam logic [23:0] TOKEN_XXX = 24'h58_58_58;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        WAIT_TX = 1'b1
    } state_t;

    // Build a 3-byte token; byte 0 of the token sits in bits [23:16].
    function automatic logic [23:0] encode_token(input logic [1:0] kind,
                                                 input logic [1:0] idx);
        logic [7:0]  digit;
        logic [23:0] tok;
        digit = 8'h30 + {6'd0, idx};
        if (idx == 2'd0) begin
            tok = TOKEN_XXX;
        end else begin
            case (kind)
                2'd1:    tok = {8'h4D, 8'h55, digit};  // "MU<d>"
                2'd2:    tok = {8'h53, 8'h55, digit};  // "SU<d>"
                default: tok = TOKEN_XXX;
            endcase
        end
        return tok;
    endfunction

    // Frame byte at position i, given the latched tokens.
    function automatic logic [7:0] frame_byte(input logic [4:0]  i,
                                              input logic [23:0] t1,
                                              input logic [23:0] t2,
                                              input logic [23:0] t3);
        logic [7:0] b;
        case (i)
            5'd0:    b = 8'h53;       // 'S'
            5'd1:    b = 8'h41;       // 'A'
            5'd2:    b = 8'h4D;       // 'M'
            5'd3:    b = 8'h2D;       // '-'
            5'd4:    b = 8'h31;       // '1'
            5'd5:    b = 8'h2E;       // '.'
            5'd6:    b = t1[23:16];
            5'd7:    b = t1[15:8];
            5'd8:    b = t1[7:0];
            5'd9:    b = 8'h2D;
            5'd10:   b = 8'h32;       // '2'
            5'd11:   b = 8'h2E;
            5'd12:   b = t2[23:16];
            5'd13:   b = t2[15:8];
            5'd14:   b = t2[7:0];
            5'd15:   b = 8'h2D;
            5'd16:   b = 8'h33;       // '3'
            5'd17:   b = 8'h2E;
            5'd18:   b = t3[23:16];
            5'd19:   b = t3[15:8];
            5'd20:   b = t3[7:0];
            5'd21:   b = 8'h2D;
            5'd22:   b = 8'h23;       // '#'
`ifdef SAM_ENC_CRLF_EN
            5'd23:   b = 8'h0D;
            5'd24:   b = 8'h0A;
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t      state_r,    state_s;
    logic [4:0]  idx_r,      idx_s;
    logic [23:0] tok1_r,     tok1_s;
    logic [23:0] tok2_r,     tok2_s;
    logic [23:0] tok3_r,     tok3_s;
    logic [7:0]  tx_data_r,  tx_data_s;
    logic        tx_start_r, tx_start_s;
    logic        busy_r,     busy_s;
    logic        msg_done_r, msg_done_s;
    logic [4:0]  next_idx_s;

    assign next_idx_s = idx_r + 5'd1;

    // Next-state and output decode; every output is registered below.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        tok1_s     = tok1_r;
        tok2_s     = tok2_r;
        tok3_s     = tok3_r;
        tx_data_s  = tx_data_r;
        tx_start_s = 1'b0;
        busy_s     = busy_r;
        msg_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.send_req) begin
                    tok1_s     = encode_token(bus.kind1, bus.idx1);
                    tok2_s     = encode_token(bus.kind2, bus.idx2);
                    tok3_s     = encode_token(bus.kind3, bus.idx3);
                    idx_s      = 5'd0;
                    tx_data_s  = 8'h53;  // byte 0 is always 'S'
                    tx_start_s = 1'b1;
                    busy_s     = 1'b1;
                    state_s    = WAIT_TX;
                end else begin
                    state_s    = IDLE;
                end
            end
            WAIT_TX: begin
                if (bus.tx_done) begin
                    if (idx_r == LAST_IDX) begin
                        idx_s      = 5'd0;
                        busy_s     = 1'b0;
                        msg_done_s = 1'b1;
                        state_s    = IDLE;
                    end else begin
                        idx_s      = next_idx_s;
                        tx_data_s  = frame_byte(next_idx_s, tok1_r, tok2_r, tok3_r);
                        tx_start_s = 1'b1;
                        state_s    = WAIT_TX;
                    end
                end else begin
                    state_s = WAIT_TX;
                end
            end
            default: begin
                idx_s   = 5'd0;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, byte index, latched tokens and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            idx_r      <= 5'd0;
            tok1_r     <= TOKEN_XXX;
            tok2_r     <= TOKEN_XXX;
            tok3_r     <= TOKEN_XXX;
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            msg_done_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            tok1_r     <= tok1_s;
            tok2_r     <= tok2_s;
            tok3_r     <= tok3_s;
            tx_data_r  <= tx_data_s;
            tx_start_r <= tx_start_s;
            busy_r     <= busy_s;
            msg_done_r <= msg_done_s;
        end
    end

    assign bus.tx_data  = tx_data_r;
    assign bus.tx_start = tx_start_r;
    assign bus.busy     = busy_r;
    assign bus.msg_done = msg_done_r;

endmodule
